vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 135 +++++++++++++
 tb/tb_vram_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: VGA pixel fetches share one RAM port with a queued game-logic
// write stream; reads win unless the oldest queued write has waited STARVE_MAX cycles.
module vram_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              iVgaReq,
    input  logic [ADDR_W-1:0] iVgaAddr,
    output logic [DATA_W-1:0] oVgaData,
    output logic              oVgaValid,
    output logic              oVgaMiss,
    input  logic              iWrReq,
    input  logic [ADDR_W-1:0] iWrAddr,
    input  logic [DATA_W-1:0] iWrData,
    output logic              oWrReady,
    output logic [2:0]        oFifoLevel,
    output logic [ADDR_W-1:0] oRamAddr,
    output logic [DATA_W-1:0] oRamWrData,
    output logic              oRamWe,
    input  logic [DATA_W-1:0] iRamRdData
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        G_IDLE,
        G_READ,
        G_WRITE
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_ent_t;

    wr_ent_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [LVL_W-1:0]   level;
    logic [CNT_W-1:0]   starve;
    logic [1:0]         vld_pipe;
    logic [1:0]         miss_pipe;
    logic [DATA_W-1:0]  data_q;

    grant_e             grant;
    wr_ent_t            head;
    logic               empty, full, force_wr, push, pop;

    assign head     = fifo_mem[rd_ptr];
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign force_wr = !empty && (starve == CNT_W'(STARVE_MAX));

    // Refusal is based on the registered level, so a same-cycle pop never frees a full slot.
    assign oWrReady = !Reset && !full;
    assign push     = iWrReq && oWrReady;
    assign pop      = (grant == G_WRITE);

    always_comb begin
        grant = G_IDLE;
        if (Reset)
            grant = G_IDLE;
        else if (force_wr)
            grant = G_WRITE;
        else if (iVgaReq)
            grant = G_READ;
        else if (!empty)
            grant = G_WRITE;
    end

    always_comb begin
        oRamAddr   = '0;
        oRamWrData = '0;
        oRamWe     = 1'b0;
        case (grant)
            G_READ: oRamAddr = iVgaAddr;
            G_WRITE: begin
                oRamAddr   = head.addr;
                oRamWrData = head.data;
                oRamWe     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (push)
            fifo_mem[wr_ptr] <= '{addr: iWrAddr, data: iWrData};
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            starve    <= '0;
            vld_pipe  <= '0;
            miss_pipe <= '0;
            data_q    <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase

            // Wait time restarts whenever the head changes or the queue drains.
            if (empty || pop)
                starve <= '0;
            else if (starve != CNT_W'(STARVE_MAX))
                starve <= starve + CNT_W'(1);

            vld_pipe  <= {vld_pipe[0], grant == G_READ};
            miss_pipe <= {miss_pipe[0], force_wr && iVgaReq};
            if (vld_pipe[0])
                data_q <= iRamRdData;
        end
    end

    assign oVgaValid  = vld_pipe[1] && !Reset;
    assign oVgaMiss   = miss_pipe[1] && !Reset;
    assign oVgaData   = Reset ? '0 : data_q;
    assign oFifoLevel = Reset ? 3'd0 : 3'(level);

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized + directed bench for vram_arbiter against a queue-based behavioural model.
module tb_vram_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iVgaReq;
    logic [15:0] iVgaAddr;
    logic [2:0]  oVgaData;
    logic        oVgaValid;
    logic        oVgaMiss;
    logic        iWrReq;
    logic [15:0] iWrAddr;
    logic [2:0]  iWrData;
    logic        oWrReady;
    logic [2:0]  oFifoLevel;
    logic [15:0] oRamAddr;
    logic [2:0]  oRamWrData;
    logic        oRamWe;
    logic [2:0]  iRamRdData;

    vram_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .iVgaReq(iVgaReq), .iVgaAddr(iVgaAddr),
        .oVgaData(oVgaData), .oVgaValid(oVgaValid), .oVgaMiss(oVgaMiss),
        .iWrReq(iWrReq), .iWrAddr(iWrAddr), .iWrData(iWrData),
        .oWrReady(oWrReady), .oFifoLevel(oFifoLevel),
        .oRamAddr(oRamAddr), .oRamWrData(oRamWrData), .oRamWe(oRamWe),
        .iRamRdData(iRamRdData)
    );

    always #5 Clock = ~Clock;

    localparam int DEPTH = 4;
    localparam int SMAX  = 8;

    typedef struct {
        logic [15:0] a;
        logic [2:0]  d;
    } ent_t;

    // Model: queue contents, cycles the head has waited, and what each of the last
    // two cycles did to the VGA port (0 nothing, 1 read served, 2 read dropped).
    ent_t       q[$];
    int         starve;
    int         p1, p2;
    logic [2:0] exp_data;

    int n_chk = 0;
    int n_fail = 0;

    logic        obs_we, obs_miss, obs_valid, obs_ready;
    logic [15:0] obs_addr;
    logic [2:0]  obs_data, obs_wdata, obs_level;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic req, input logic [15:0] va,
                        input logic wr, input logic [15:0] wa, input logic [2:0] wd,
                        input logic [2:0] rd);
        int          g;
        bit          fw, acc, was_empty;
        logic [15:0] ea;
        Reset = rst; iVgaReq = req; iVgaAddr = va;
        iWrReq = wr; iWrAddr = wa; iWrData = wd; iRamRdData = rd;
        #2;
        fw = (q.size() > 0) && (starve == SMAX);
        if (rst)                g = 0;
        else if (fw)            g = 2;
        else if (req)           g = 1;
        else if (q.size() > 0)  g = 2;
        else                    g = 0;
        ea = 16'h0;
        if (g == 1) ea = va;
        if (g == 2) ea = q[0].a;

        chk("ram_we", 32'(oRamWe), 32'(g == 2));
        chk("ram_addr", 32'(oRamAddr), 32'(ea));
        if (g == 2) chk("ram_wdata", 32'(oRamWrData), 32'(q[0].d));
        chk("wr_ready", 32'(oWrReady), 32'(!rst && q.size() < DEPTH));
        chk("level", 32'(oFifoLevel), rst ? 32'd0 : 32'(q.size()));
        chk("vga_valid", 32'(oVgaValid), 32'(!rst && p2 == 1));
        chk("vga_miss", 32'(oVgaMiss), 32'(!rst && p2 == 2));
        chk("vga_data", 32'(oVgaData), rst ? 32'd0 : 32'(exp_data));

        obs_we = oRamWe; obs_miss = oVgaMiss; obs_valid = oVgaValid;
        obs_ready = oWrReady; obs_addr = oRamAddr; obs_data = oVgaData;
        obs_wdata = oRamWrData; obs_level = oFifoLevel;

        if (rst) begin
            q.delete();
            starve = 0; p1 = 0; p2 = 0; exp_data = 3'd0;
        end else begin
            acc       = wr && (q.size() < DEPTH);
            was_empty = (q.size() == 0);
            if (p1 == 1) exp_data = rd;
            p2 = p1;
            p1 = (g == 1) ? 1 : ((fw && req) ? 2 : 0);
            if (was_empty || g == 2) starve = 0;
            else if (starve < SMAX)  starve = starve + 1;
            if (g == 2) void'(q.pop_front());
            if (acc) q.push_back('{a: wa, d: wd});
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, 16'h0, 1'b0, 16'h0, 3'd0, 3'($urandom));
    endtask

    initial begin
        starve = 0; p1 = 0; p2 = 0; exp_data = 3'd0;
        Reset = 1'b1; iVgaReq = 0; iVgaAddr = 0; iWrReq = 0; iWrAddr = 0;
        iWrData = 0; iRamRdData = 0;
        @(posedge Clock);
        #1;
        idle(1'b1);
        idle(1'b1);
        chk("rst_ready", 32'(obs_ready), 32'd0);
        idle(1'b0);
        chk("post_rst_ready", 32'(obs_ready), 32'd1);

        // Single read with known RAM data.
        step(0, 1, 16'h0010, 0, 16'h0, 3'd0, 3'd0);
        chk("r_addr", 32'(obs_addr), 32'h0010);
        step(0, 0, 16'h0, 0, 16'h0, 3'd0, 3'b101);
        step(0, 0, 16'h0, 0, 16'h0, 3'd0, 3'd0);
        chk("r_valid", 32'(obs_valid), 32'd1);
        chk("r_data", 32'(obs_data), 32'h5);

        // Write drains on the first idle cycle after push.
        idle(1'b1);
        step(0, 0, 16'h0, 1, 16'h0200, 3'b011, 3'd0);
        idle(1'b0);
        chk("w_we", 32'(obs_we), 32'd1);
        chk("w_addr", 32'(obs_addr), 32'h0200);
        chk("w_data", 32'(obs_wdata), 32'h3);
        idle(1'b0);
        chk("w_level", 32'(obs_level), 32'd0);

        // Starvation: one write under continuous reads.
        idle(1'b1);
        for (int c = 0; c < 14; c++) begin
            step(0, 1, 16'(c), c == 0, 16'h0ABC, 3'd6, 3'($urandom));
            if (c == 8)  chk("starve_c8_we", 32'(obs_we), 32'd0);
            if (c == 9)  chk("starve_c9_we", 32'(obs_we), 32'd1);
            if (c == 11) chk("starve_c11_miss", 32'(obs_miss), 32'd1);
            if (c == 12) chk("starve_c12_valid", 32'(obs_valid), 32'd1);
        end

        // Queue full under continuous reads; 5th push refused.
        idle(1'b1);
        for (int c = 0; c < 30; c++) begin
            step(0, 1, 16'h1000 + 16'(c), c < 5, 16'h0300 + 16'(c), 3'(c), 3'($urandom));
            if (c == 4) chk("full_ready", 32'(obs_ready), 32'd0);
            if (c == 9) chk("full_force_addr", 32'(obs_addr), 32'h0300);
        end

        // Reset with three queued writes and reads in flight.
        idle(1'b1);
        for (int c = 0; c < 3; c++)
            step(0, 1, 16'h2000, 1, 16'h0400 + 16'(c), 3'd1, 3'd2);
        idle(1'b1);
        chk("mid_rst_level", 32'(obs_level), 32'd0);
        for (int c = 0; c < 3; c++) step(0, 1, 16'h2100, 0, 16'h0, 3'd0, 3'd7);
        chk("after_rst_ready", 32'(obs_ready), 32'd1);

        // Interleave: alternate reads with two queued writes.
        idle(1'b1);
        step(0, 1, 16'h0001, 1, 16'h0500, 3'd4, 3'd0);
        step(0, 1, 16'h0002, 1, 16'h0501, 3'd5, 3'd0);
        for (int c = 0; c < 6; c++) begin
            step(0, c[0] == 1'b0, 16'h0003, 0, 16'h0, 3'd0, 3'($urandom));
            if (c == 1) chk("ilv_w0", 32'(obs_addr), 32'h0500);
            if (c == 3) chk("ilv_w1", 32'(obs_addr), 32'h0501);
            if (c == 5) chk("ilv_nomiss", 32'(obs_miss), 32'd0);
        end

        // Randomized traffic with varying read/write pressure.
        for (int blk = 0; blk < 20; blk++) begin
            int rp, wp;
            rp = $urandom_range(0, 100);
            wp = $urandom_range(0, 100);
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < rp, 16'($urandom),
                     $urandom_range(0, 99) < wp, 16'($urandom), 3'($urandom),
                     3'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
